pwm_capture: RTL and testbench
==============================

# pwm_capture

Receive-side counterpart of the team's 10-bit PWM generator. Samples an asynchronous PWM waveform, measures high time and period in clock cycles, and publishes the recovered 10-bit duty word once per period. It also reports out-of-tolerance periods and stuck-high or stuck-low inputs. It sits at the motor-control boundary, for loopback verification of the drive path and for decoding PWM-coded feedback from external drivers.

## Interface
- `PERIOD`, 1024: nominal period in clocks; must be 2^`DUTY_W`.
- `TOL`, 8: allowed |period − `PERIOD`| before `period_err`.
- `DUTY_W`, 10: duty word width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `pwm_in`  in  1  asynchronous PWM waveform.
- `duty`  out  `DUTY_W`  last recovered duty; reset 0.
- `duty_vld`  out  1  one-cycle pulse when `duty`, `period_err` or `stuck` updates; reset 0.
- `period_err`  out  1  last measured period out of tolerance; reset 0.
- `stuck`  out  1  input had no edge for 2·`PERIOD` clocks; reset 0.

## Operation
- Encoding contract matches the generator:
  - High time = duty+1 clocks.
  - Duty `PERIOD`−1 is a constant-high input.
  - Constant low is never legal and decodes as duty 0 with `stuck`.
- `pwm_in` passes through a 2-flop synchronizer to give `s`. A third flop holds `s_d`.
  - `rise` = `s` & ~`s_d`.
  - `fall` = ~`s` & `s_d`.
- `hi_cnt` counter: 11 bits, saturates at 2047.
- `per_cnt` counter: clog2(2·`PERIOD`)+1 bits, saturates.
- FSM states:
  - **IDLE**: after reset or stuck. On `rise`: `per_cnt`←1, `hi_cnt`←1, go to HIGH. No publish, because no complete period has been seen.
  - **HIGH**: `per_cnt`++, `hi_cnt`++ each clock. On `fall`: go to LOW, freeze `hi_cnt`.
  - **LOW**: `per_cnt`++. On `rise`: publish, then `per_cnt`←1, `hi_cnt`←1, go to HIGH.
- Publish (registered):
  - `duty` ← min(`hi_cnt`−1, `PERIOD`−1).
  - `period_err` ← (|`per_cnt` − `PERIOD`| > `TOL`).
  - `stuck` ← 0.
  - `duty_vld` ← 1 for one clock.
- Timeout: `per_cnt` reaches 2·`PERIOD` with no edge in the current state.
  - From HIGH: `duty`←`PERIOD`−1, `stuck`←1, `duty_vld` pulse, go to IDLE.
  - From LOW or IDLE: `duty`←0, `stuck`←1, `duty_vld` pulse, go to IDLE. IDLE's `per_cnt` runs from reset and is cleared on timeout, so a dead input re-reports every 2·`PERIOD` clocks.
- In IDLE after a stuck-high report, the following `fall` is ignored. Capture restarts at the next `rise`.
- `stuck` clears only on the next publish.
- `duty` and `period_err` hold between publishes.
- A `hi_cnt` overflow while `per_cnt` is in tolerance clamps `duty` to `PERIOD`−1.

## Timing
- Latency: a `pwm_in` rising transition sampled at edge N gives `rise` in cycle N+2 and `duty_vld`/`duty` at N+3.
- Fall detection has the same 2-cycle synchronizer delay. High time measurement is therefore unbiased.
- Steady 1024-clock input: `duty_vld` exactly every 1024 clocks.
- `rise` and timeout in the same cycle: `rise` wins (publish, not stuck).
- Minimum decodable high or low width is 1 clock. Pulses narrower than a clock may be lost; this is not an error.
- Reset mid-operation: all outputs and counters are 0 and the FSM is IDLE immediately. The first publish needs one full rise-to-rise period after reset.

## Structure
- Package `pwm_pkg` holds:
  - `DUTY_W`, `PERIOD` defaults (shared with the generator).
  - FSM enum `cap_state_t` {IDLE, HIGH, LOW}.
- Sub-module `sync2`: generic 2-flop synchronizer with async active-low reset to 0. It is reused elsewhere for sensor inputs.
- All outputs are registered. No combinational path from `pwm_in`.

## Test plan
- Generator-style input with 512 high / 512 low for 4 periods -> 3 `duty_vld` pulses (the first rise only starts capture), each 1024 clocks apart, `duty`=511, `period_err`=0.
- 1 high / 1023 low -> `duty`=0. 1023 high / 1 low -> `duty`=1022. `stuck`=0 throughout.
- Hold high 2048 clocks after a rise -> pulse with `duty`=1023, `stuck`=1. Hold low 2048 clocks from reset -> `duty`=0, `stuck`=1, and it repeats every 2048 clocks.
- Period 1032 (in tolerance) -> `period_err`=0. Period 900 with 450 high -> `period_err`=1, `duty`=449. Period 1100 with 1090 high -> `duty`=1023 (clamped), `period_err`=1.
- Assert `rst_n` mid-HIGH -> outputs 0 at once. After release, no `duty_vld` until the second rise, and that publish is correct.
- `rise` coincident with the 2·`PERIOD` timeout -> normal publish, `stuck`=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM generator/capture pair.
package pwm_pkg;

   localparam int PWM_DUTY_W = 10;
   localparam int PWM_PERIOD = 1 << PWM_DUTY_W;
   localparam int PWM_TOL    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer, resets to 0.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Recovers the duty word from a PWM waveform once per period and flags
// out-of-tolerance periods and inputs stuck at either level.
//
// state | meaning
// IDLE  | no period in progress; waiting for a rise, timing out a dead input
// HIGH  | measuring high time and period
// LOW   | high time frozen, measuring rest of period until next rise
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int PERIOD = PWM_PERIOD,
   parameter int TOL    = PWM_TOL,
   parameter int DUTY_W = PWM_DUTY_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_vld,
   output logic              period_err,
   output logic              stuck
);

   localparam int HI_W  = DUTY_W + 1;
   localparam int PER_W = $clog2(2 * PERIOD) + 1;

   localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
   localparam logic [PER_W-1:0]  PER_TO   = PER_W'(2 * PERIOD);
   localparam logic [PER_W-1:0]  PER_HI   = PER_W'(PERIOD + TOL);
   localparam logic [PER_W-1:0]  PER_LO   = PER_W'(PERIOD - TOL);
   localparam logic [PER_W-1:0]  PER_MAX  = '1;
   localparam logic [HI_W-1:0]   HI_ONE   = HI_W'(1);
   localparam logic [HI_W-1:0]   HI_MAX   = '1;
   localparam logic [HI_W-1:0]   HI_CLAMP = HI_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD - 1);

   cap_state_t        state;
   logic              s;
   logic              s_d;
   logic              rise;
   logic              fall;
   logic              timeout;
   logic [PER_W-1:0]  per_cnt;
   logic [PER_W-1:0]  per_inc;
   logic [HI_W-1:0]   hi_cnt;
   logic [HI_W-1:0]   hi_inc;
   logic [HI_W-1:0]   hi_m1;
   logic [DUTY_W-1:0] duty_pub;
   logic              err_pub;

   sync2 #(.W(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pwm_in),
      .q     (s)
   );

   assign rise    = s & ~s_d;
   assign fall    = ~s & s_d;
   assign timeout = (per_cnt >= PER_TO);
   assign per_inc = (per_cnt == PER_MAX) ? per_cnt : per_cnt + PER_ONE;
   assign hi_inc  = (hi_cnt == HI_MAX) ? hi_cnt : hi_cnt + HI_ONE;

   // High time is duty+1 clocks; anything longer than a full period clamps.
   assign hi_m1    = hi_cnt - HI_ONE;
   assign duty_pub = (hi_m1 > HI_CLAMP) ? DUTY_MAX : hi_m1[DUTY_W-1:0];
   assign err_pub  = (per_cnt > PER_HI) || (per_cnt < PER_LO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         s_d        <= 1'b0;
         per_cnt    <= '0;
         hi_cnt     <= '0;
         duty       <= '0;
         duty_vld   <= 1'b0;
         period_err <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         s_d      <= s;
         duty_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  per_cnt <= PER_ONE;
                  hi_cnt  <= HI_ONE;
                  state   <= HIGH;
               end else if (timeout) begin
                  // The timeout clock itself opens the next interval, so a
                  // dead input re-reports every 2*PERIOD clocks.
                  duty     <= '0;
                  stuck    <= 1'b1;
                  duty_vld <= 1'b1;
                  per_cnt  <= PER_ONE;
               end else begin
                  per_cnt <= per_inc;
               end
            end
            HIGH: begin
               if (fall) begin
                  per_cnt <= per_inc;
                  state   <= LOW;
               end else if (timeout) begin
                  duty     <= DUTY_MAX;
                  stuck    <= 1'b1;
                  duty_vld <= 1'b1;
                  per_cnt  <= PER_ONE;
                  state    <= IDLE;
               end else begin
                  per_cnt <= per_inc;
                  hi_cnt  <= hi_inc;
               end
            end
            LOW: begin
               if (rise) begin
                  duty       <= duty_pub;
                  period_err <= err_pub;
                  stuck      <= 1'b0;
                  duty_vld   <= 1'b1;
                  per_cnt    <= PER_ONE;
                  hi_cnt     <= HI_ONE;
                  state      <= HIGH;
               end else if (timeout) begin
                  duty     <= '0;
                  stuck    <= 1'b1;
                  duty_vld <= 1'b1;
                  per_cnt  <= PER_ONE;
                  state    <= IDLE;
               end else begin
                  per_cnt <= per_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: duty decode, tolerance, stuck and reset.
module tb_pwm_capture;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pwm_in;
   logic [9:0] duty;
   logic       duty_vld;
   logic       period_err;
   logic       stuck;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int cyc;
      int duty;
      int err;
      int stk;
   } ev_t;

   ev_t q[$];

   pwm_capture dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .duty_vld   (duty_vld),
      .period_err (period_err),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (duty_vld) begin
         ev_t e;
         e.cyc  = cyc;
         e.duty = int'(duty);
         e.err  = int'(period_err);
         e.stk  = int'(stuck);
         q.push_back(e);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
   endtask

   task automatic drive(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // nper periods of hi/lo give nper-1 publishes; the first rise only arms capture.
   task automatic cap_test(input string name, input int hi, input int lo, input int nper,
                           input int exp_duty, input int exp_err);
      int t1 = 0;
      do_reset();
      drive(1'b0, 5);
      for (int p = 0; p < nper; p++) begin
         if (p == 1) t1 = cyc;
         drive(1'b1, hi);
         drive(1'b0, lo);
      end
      chk({name, "_npulse"}, q.size(), nper - 1);
      for (int i = 0; i < q.size(); i++) begin
         chk($sformatf("%s_duty%0d", name, i), q[i].duty, exp_duty);
         chk($sformatf("%s_err%0d", name, i), q[i].err, exp_err);
         chk($sformatf("%s_stuck%0d", name, i), q[i].stk, 0);
         if (i == 0)
            chk($sformatf("%s_lat", name), q[i].cyc, t1 + 3);
         else
            chk($sformatf("%s_gap%0d", name, i), q[i].cyc - q[i-1].cyc, hi + lo);
      end
   endtask

   initial begin
      int t;
      int t2;
      int r;

      do_reset();
      chk("rst_duty", int'(duty), 0);
      chk("rst_vld", int'(duty_vld), 0);
      chk("rst_err", int'(period_err), 0);
      chk("rst_stuck", int'(stuck), 0);

      cap_test("half",   512, 512,  4, 511,  0);
      cap_test("min",      1, 1023, 2, 0,    0);
      cap_test("max",   1023, 1,    2, 1022, 0);
      cap_test("p1032",  516, 516,  2, 515,  0);
      cap_test("p1033",  517, 516,  2, 516,  1);
      cap_test("p1016",  508, 508,  2, 507,  0);
      cap_test("p1015",  508, 507,  2, 507,  1);
      cap_test("p900",   450, 450,  2, 449,  1);
      cap_test("p1100", 1090, 10,   2, 1023, 1);

      // stuck high after a rise, then recovery on the next full period
      do_reset();
      drive(1'b0, 5);
      t = cyc;
      drive(1'b1, 2100);
      chk("sh_npulse", q.size(), 1);
      chk("sh_stuck_live", int'(stuck), 1);
      if (q.size() >= 1) begin
         chk("sh_duty", q[0].duty, 1023);
         chk("sh_stuck", q[0].stk, 1);
         chk("sh_cyc", q[0].cyc, t + 3 + 2048);
      end
      drive(1'b0, 1000);
      t2 = cyc;
      drive(1'b1, 600);
      drive(1'b0, 424);
      drive(1'b1, 1);
      drive(1'b0, 5);
      chk("shr_npulse", q.size(), 2);
      if (q.size() >= 2) begin
         chk("shr_duty", q[1].duty, 599);
         chk("shr_stuck", q[1].stk, 0);
         chk("shr_err", q[1].err, 0);
         chk("shr_cyc", q[1].cyc, t2 + 3 + 1024);
      end

      // stuck low from reset re-reports every 2*PERIOD clocks
      do_reset();
      r = cyc;
      drive(1'b0, 2049 + 2048 + 10);
      chk("sl_npulse", q.size(), 2);
      chk("sl_stuck_live", int'(stuck), 1);
      if (q.size() >= 2) begin
         chk("sl_duty0", q[0].duty, 0);
         chk("sl_stuck0", q[0].stk, 1);
         chk("sl_cyc0", q[0].cyc, r + 2049);
         chk("sl_duty1", q[1].duty, 0);
         chk("sl_stuck1", q[1].stk, 1);
         chk("sl_gap", q[1].cyc - q[0].cyc, 2048);
      end

      // rise lands on the same clock as the timeout
      do_reset();
      drive(1'b0, 5);
      t = cyc;
      drive(1'b1, 1000);
      drive(1'b0, 1048);
      drive(1'b1, 1);
      drive(1'b0, 5);
      chk("co_npulse", q.size(), 1);
      if (q.size() >= 1) begin
         chk("co_duty", q[0].duty, 999);
         chk("co_err", q[0].err, 1);
         chk("co_stuck", q[0].stk, 0);
         chk("co_cyc", q[0].cyc, t + 3 + 2048);
      end

      // reset asserted mid-HIGH
      do_reset();
      drive(1'b0, 5);
      drive(1'b1, 512);
      drive(1'b0, 512);
      drive(1'b1, 300);
      chk("mr_pre_npulse", q.size(), 1);
      chk("mr_pre_duty", int'(duty), 511);
      rst_n = 1'b0;
      #1;
      chk("mr_duty", int'(duty), 0);
      chk("mr_vld", int'(duty_vld), 0);
      chk("mr_err", int'(period_err), 0);
      chk("mr_stuck", int'(stuck), 0);
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
      drive(1'b0, 20);
      t = cyc;
      drive(1'b1, 400);
      drive(1'b0, 624);
      chk("mr_first_rise", q.size(), 0);
      drive(1'b1, 1);
      drive(1'b0, 5);
      chk("mr_npulse", q.size(), 1);
      if (q.size() >= 1) begin
         chk("mr_pub_duty", q[0].duty, 399);
         chk("mr_pub_err", q[0].err, 0);
         chk("mr_pub_cyc", q[0].cyc, t + 3 + 1024);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
